// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: round-robin arbiter that locks a grant while the winner keeps
// requesting, bounded by a MAX_HOLD timeout, with a one-cycle idle bubble
// between grants and a rotating one-hot priority pointer.
// Optional saturating grant/timeout counters are added when the macro
// RR_ARBITER_STATS_EN is defined.
module rr_arbiter_core #(
   parameter int N = 4,
   parameter int MAX_HOLD = 16,
   localparam int IDW = $clog2(N)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id,
   output logic           timeout,
   output logic [N-1:0]   pointer
`ifdef RR_ARBITER_STATS_EN
   ,
   output logic [15:0]    grant_count,
   output logic [15:0]    timeout_count
`endif
);

   localparam int HCW = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [N-1:0]   r_grant;
   logic [N-1:0]   w_nextGrant;
   logic [IDW-1:0] r_grantId;
   logic [IDW-1:0] w_nextGrantId;
   logic [HCW-1:0] r_holdCnt;
   logic [HCW-1:0] w_nextHoldCnt;
   logic           r_timeout;
   logic           w_nextTimeout;
   logic [N-1:0]   r_pointer;
   logic [N-1:0]   w_nextPointer;

   logic [IDW-1:0] w_ptrIdx;
   logic [N-1:0]   w_rotReq;
   logic           w_winFound;
   logic [IDW-1:0] w_winOffset;
   logic [IDW:0]   w_winSum;
   logic [IDW-1:0] w_winIdx;
   logic           w_ownerReq;

   // Convert the one-hot priority pointer into the binary scan start position
   always_comb begin
      w_ptrIdx = '0;
      for (int i = 0; i < N; i++) begin
         if (r_pointer[i]) begin
            w_ptrIdx = IDW'(i);
         end
      end
   end

   // Rotate the request vector so the pointer position lands on bit 0
   assign w_rotReq = N'({req, req} >> w_ptrIdx);

   // Find the lowest set bit of the rotated requests, i.e. the distance from the pointer
   always_comb begin
      w_winFound  = 1'b0;
      w_winOffset = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rotReq[k]) begin
            w_winFound  = 1'b1;
            w_winOffset = IDW'(k);
         end
      end
   end

   // Map the offset back to an absolute requester index, wrapping past N-1
   always_comb begin
      w_winSum = {1'b0, w_ptrIdx} + {1'b0, w_winOffset};
      if (w_winSum >= (IDW + 1)'(N)) begin
         w_winSum = w_winSum - (IDW + 1)'(N);
      end
      w_winIdx = w_winSum[IDW-1:0];
   end

   // The current owner still wants the resource (grant is one-hot or zero)
   assign w_ownerReq = |(req & r_grant);

   // Next-state and next-output decisions for the IDLE/BUSY arbiter
   always_comb begin
      w_nextState   = r_state;
      w_nextGrant   = r_grant;
      w_nextGrantId = r_grantId;
      w_nextHoldCnt = r_holdCnt;
      w_nextTimeout = 1'b0;
      w_nextPointer = r_pointer;
      case (r_state)
         IDLE: begin
            if (w_winFound) begin
               w_nextState   = BUSY;
               w_nextGrant   = N'(1) << w_winIdx;
               w_nextGrantId = w_winIdx;
               w_nextHoldCnt = HCW'(1);
            end
         end
         BUSY: begin
            if (!w_ownerReq || (r_holdCnt == HCW'(MAX_HOLD))) begin
               w_nextState   = IDLE;
               w_nextGrant   = '0;
               w_nextGrantId = '0;
               w_nextHoldCnt = '0;
               w_nextPointer = {r_grant[N-2:0], r_grant[N-1]};
               w_nextTimeout = w_ownerReq;
            end else begin
               w_nextHoldCnt = r_holdCnt + HCW'(1);
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State and output registers; reset overrides everything including a live grant
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_grantId <= '0;
         r_holdCnt <= '0;
         r_timeout <= 1'b0;
         r_pointer <= N'(1);
      end else begin
         r_state   <= w_nextState;
         r_grant   <= w_nextGrant;
         r_grantId <= w_nextGrantId;
         r_holdCnt <= w_nextHoldCnt;
         r_timeout <= w_nextTimeout;
         r_pointer <= w_nextPointer;
      end
   end

   assign grant       = r_grant;
   assign grant_valid = |r_grant;
   assign grant_id    = r_grantId;
   assign timeout     = r_timeout;
   assign pointer     = r_pointer;

`ifdef RR_ARBITER_STATS_EN
   logic [15:0] r_grantCount;
   logic [15:0] r_timeoutCount;

   // Saturating counts of grants issued and grants force-released
   always_ff @(posedge clock) begin
      if (reset) begin
         r_grantCount   <= '0;
         r_timeoutCount <= '0;
      end else begin
         if ((r_state == IDLE) && w_winFound && (r_grantCount != 16'hFFFF)) begin
            r_grantCount <= r_grantCount + 16'd1;
         end
         if (w_nextTimeout && (r_timeoutCount != 16'hFFFF)) begin
            r_timeoutCount <= r_timeoutCount + 16'd1;
         end
      end
   end

   assign grant_count   = r_grantCount;
   assign timeout_count = r_timeoutCount;
`endif

endmodule

// File: tb/tb_rr_arbiter_core.sv
// tb_rr_arbiter_core: table-driven and sequence checks for rr_arbiter_core
// with a scoreboard queue of expected post-edge outputs.
module tb_rr_arbiter_core;

   localparam int N = 4;
   localparam int MAX_HOLD = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic       grantValid;
   logic [1:0] grantId;
   logic       timeout;
   logic [3:0] pointer;
`ifdef RR_ARBITER_STATS_EN
   logic [15:0] grantCount;
   logic [15:0] timeoutCount;
`endif

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] id;
      logic       tmo;
      logic [3:0] ptr;
   } vec_t;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] id;
      logic       tmo;
      logic [3:0] ptr;
   } exp_t;

   exp_t expQ[$];
   vec_t vecs[19];
   int   total = 0;
   int   bad = 0;
   int   step = 0;

   rr_arbiter_core #(
      .N(N),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .req(req),
      .grant(grant),
      .grant_valid(grantValid),
      .grant_id(grantId),
      .timeout(timeout),
      .pointer(pointer)
`ifdef RR_ARBITER_STATS_EN
      ,
      .grant_count(grantCount),
      .timeout_count(timeoutCount)
`endif
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Single field comparison with failure report
   task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s step=%0d got=%0h want=%0h", name, step, got, want);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the next edge
   task automatic applyStimulus(input logic rst, input logic [3:0] r,
                                input logic [3:0] eg, input logic [1:0] eid,
                                input logic et, input logic [3:0] ep);
      exp_t e;
      reset = rst;
      req = r;
      e.grant = eg;
      e.id = eid;
      e.tmo = et;
      e.ptr = ep;
      expQ.push_back(e);
      @(posedge clock);
      #1;
      step++;
   endtask

   // Pop the oldest expectation and compare every observable output
   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard step=%0d got=empty want=entry", step);
         return;
      end
      e = expQ.pop_front();
      compareField("grant", 32'(grant), 32'(e.grant));
      compareField("grant_valid", 32'(grantValid), 32'(e.grant != 4'b0000));
      compareField("grant_id", 32'(grantId), 32'(e.id));
      compareField("timeout", 32'(timeout), 32'(e.tmo));
      compareField("pointer", 32'(pointer), 32'(e.ptr));
   endtask

   // Main test sequence
   initial begin
      reset = 1'b1;
      req = 4'b0000;

      // Reset, single request held five cycles, wrap scan, ignore-others, rotation
      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001};
      vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0001};
      vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0001};
      vecs[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0001};
      vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0001};
      vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0001};
      vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b1000};
      vecs[7]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, 4'b1000};
      vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0010};
      vecs[9]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, 4'b0010};
      vecs[10] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, 4'b0010};
      vecs[11] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, 4'b0010};
      vecs[12] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, 4'b0010};
      vecs[13] = '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0, 4'b0010};
      vecs[14] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b0, 4'b0010};
      vecs[15] = '{1'b0, 4'b1100, 4'b0000, 2'd0, 1'b0, 4'b0100};
      vecs[16] = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b0, 4'b0100};
      vecs[17] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b1000};
      vecs[18] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b1000};

      #1;
      for (int v = 0; v < 19; v++) begin
         applyStimulus(vecs[v].rst, vecs[v].req, vecs[v].grant, vecs[v].id, vecs[v].tmo, vecs[v].ptr);
         checkOutput();
      end

      // All requesters active: each grant lasts MAX_HOLD cycles then times out
      $display("[TB] all-request rotation with timeouts");
      applyStimulus(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'b0001);
      checkOutput();
      for (int g = 0; g < 5; g++) begin
         for (int h = 1; h <= MAX_HOLD; h++) begin
            applyStimulus(1'b0, 4'b1111, 4'(1 << (g % 4)), 2'(g % 4), 1'b0, 4'(1 << (g % 4)));
            checkOutput();
         end
         applyStimulus(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1, 4'(1 << ((g + 1) % 4)));
         checkOutput();
`ifdef RR_ARBITER_STATS_EN
         if (g == 3) begin
            compareField("grant_count", 32'(grantCount), 32'd4);
            compareField("timeout_count", 32'(timeoutCount), 32'd4);
         end
`endif
      end
      applyStimulus(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001);
      checkOutput();
`ifdef RR_ARBITER_STATS_EN
      compareField("grant_count_reset", 32'(grantCount), 32'd0);
      compareField("timeout_count_reset", 32'(timeoutCount), 32'd0);
`endif

      // Reset in the middle of a grant at hold count 7, then re-grant
      $display("[TB] reset during active grant");
      for (int h = 1; h <= 7; h++) begin
         applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, 4'b0001);
         checkOutput();
      end
      applyStimulus(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 4'b0001);
      checkOutput();
      applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, 4'b0001);
      checkOutput();
      applyStimulus(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0100);
      checkOutput();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
